// File: rtl/wimax_pkg.sv
// Shared 802.16 OFDM constants and rate lookups, used by fec, the interleaver
// and the mapper.
//   rate_legal  : rate_id in 0..6
//   rate_ncpc   : coded bits per subcarrier (1,2,4,6); illegal ids map to BPSK
//   ncpc_s      : max(Ncpc/2, 1)
//   ncpc_q      : Ncbps/16 = 12*Ncpc
//   ncpc_ncbps  : coded bits per OFDM symbol = 192*Ncpc
package wimax_pkg;

  localparam int unsigned NCBPS_MAX = 1152;
  localparam int unsigned AW        = 11;
  localparam int unsigned N_DATA_SC = 192;
  localparam int unsigned INTLV_D   = 16;

  localparam logic [3:0] RATE_BPSK_1_2  = 4'd0;
  localparam logic [3:0] RATE_QPSK_1_2  = 4'd1;
  localparam logic [3:0] RATE_QPSK_3_4  = 4'd2;
  localparam logic [3:0] RATE_16QAM_1_2 = 4'd3;
  localparam logic [3:0] RATE_16QAM_3_4 = 4'd4;
  localparam logic [3:0] RATE_64QAM_2_3 = 4'd5;
  localparam logic [3:0] RATE_64QAM_3_4 = 4'd6;

  function automatic logic rate_legal(input logic [3:0] rate_id);
    return rate_id <= RATE_64QAM_3_4;
  endfunction

  function automatic logic [2:0] rate_ncpc(input logic [3:0] rate_id);
    case (rate_id)
      RATE_QPSK_1_2,  RATE_QPSK_3_4:  return 3'd2;
      RATE_16QAM_1_2, RATE_16QAM_3_4: return 3'd4;
      RATE_64QAM_2_3, RATE_64QAM_3_4: return 3'd6;
      default:                        return 3'd1;
    endcase
  endfunction

  function automatic logic [1:0] ncpc_s(input logic [2:0] ncpc);
    case (ncpc)
      3'd4:    return 2'd2;
      3'd6:    return 2'd3;
      default: return 2'd1;
    endcase
  endfunction

  function automatic logic [6:0] ncpc_q(input logic [2:0] ncpc);
    case (ncpc)
      3'd2:    return 7'd24;
      3'd4:    return 7'd48;
      3'd6:    return 7'd72;
      default: return 7'd12;
    endcase
  endfunction

  function automatic logic [AW-1:0] ncpc_ncbps(input logic [2:0] ncpc);
    case (ncpc)
      3'd2:    return AW'(N_DATA_SC * 2);
      3'd4:    return AW'(N_DATA_SC * 4);
      3'd6:    return AW'(N_DATA_SC * 6);
      default: return AW'(N_DATA_SC);
    endcase
  endfunction

endpackage

// File: rtl/intlv_addr_gen.sv
// Write-address generator for the two-permutation interleaver.
// Produces j_k for the current input bit k using only counters/accumulators.
//   clk, reset : clock, async active-high reset
//   start      : this step accepts k=0; ncpc is latched for the block
//   step       : advance to k+1 (wraps to 0 after the last bit)
//   ncpc       : coded bits per subcarrier, used on start
//   addr       : j_k for the current k
//   last       : current k is Ncbps-1
module intlv_addr_gen
  import wimax_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          step,
  input  logic [2:0]    ncpc,
  output logic [AW-1:0] addr,
  output logic          last
);

  logic [6:0]    q, q_cur;
  logic [1:0]    s, s_cur;
  logic [3:0]    r;            // k mod 16
  logic [6:0]    c;            // k div 16
  logic [1:0]    cm;           // c mod s
  logic [1:0]    rm;           // r mod s
  logic [AW-1:0] qr;           // Q*r
  logic [6:0]    sc;           // s*(c div s)
  logic [1:0]    diff;

  // At k=0 every term of addr is zero, so stale q/s from the previous block
  // are harmless until the first step reloads them.
  always_comb begin
    q_cur = start ? ncpc_q(ncpc) : q;
    s_cur = start ? ncpc_s(ncpc) : s;
  end

  assign diff = (cm >= rm) ? (cm - rm) : (cm + s - rm);
  assign addr = qr + AW'(sc) + AW'(diff);
  assign last = (r == 4'(INTLV_D - 1)) && (c == q - 7'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q  <= 7'd12;
      s  <= 2'd1;
      r  <= '0;
      c  <= '0;
      cm <= '0;
      rm <= '0;
      qr <= '0;
      sc <= '0;
    end else if (step) begin
      q <= q_cur;
      s <= s_cur;
      if (last) begin
        r  <= '0;
        c  <= '0;
        cm <= '0;
        rm <= '0;
        qr <= '0;
        sc <= '0;
      end else if (r == 4'(INTLV_D - 1)) begin
        r  <= '0;
        rm <= '0;
        qr <= '0;
        c  <= c + 7'd1;
        if (cm == s_cur - 2'd1) begin
          cm <= '0;
          sc <= sc + {5'd0, s_cur};
        end else begin
          cm <= cm + 2'd1;
        end
      end else begin
        r  <= r + 4'd1;
        qr <= qr + AW'(q_cur);
        rm <= (rm == s_cur - 2'd1) ? '0 : rm + 2'd1;
      end
    end
  end

endmodule

// File: rtl/ofdm_interleaver.sv
// 802.16 OFDM bit interleaver with ping-pong bank storage.
// One bank fills in permuted order while the other drains sequentially.
//   clk, reset : clock, async active-high reset
//   rate_id    : rate from fec, sampled on the first bit of each block
//   in_bits/in_valid/in_ready    : coded bit input handshake
//   out_bits/out_valid/out_ready : interleaved bit output handshake
//   rate_err   : sticky, illegal rate_id seen at a block start
module ofdm_interleaver
  import wimax_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rate_id,
  input  logic       in_bits,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       out_bits,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       rate_err
);

  logic          mem [0:1][0:NCBPS_MAX-1];
  logic [1:0]    full;
  logic          wr_bank, rd_bank, wr_first;
  logic [AW-1:0] len [0:1];
  logic [AW-1:0] rd_idx;
  logic [AW-1:0] wr_addr;
  logic [2:0]    wr_ncpc;
  logic          wr_fire, wr_start, wr_last;
  logic          rd_issue, rd_last;

  assign in_ready = !full[wr_bank];
  assign wr_fire  = in_valid && in_ready;
  assign wr_start = wr_fire && wr_first;
  assign wr_ncpc  = rate_ncpc(rate_id);

  assign rd_issue = full[rd_bank] && (!out_valid || out_ready);
  assign rd_last  = rd_idx == len[rd_bank] - AW'(1);

  intlv_addr_gen u_addr (
    .clk   (clk),
    .reset (reset),
    .start (wr_start),
    .step  (wr_fire),
    .ncpc  (wr_ncpc),
    .addr  (wr_addr),
    .last  (wr_last)
  );

  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_bank][wr_addr] <= in_bits;
  end

  // A bank is released once its final bit has moved into the output register:
  // its contents are no longer needed, so the writer can refill it on the very
  // next cycle and continuous input never sees in_ready drop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full      <= '0;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      wr_first  <= 1'b1;
      len[0]    <= '0;
      len[1]    <= '0;
      rd_idx    <= '0;
      out_bits  <= 1'b0;
      out_valid <= 1'b0;
      rate_err  <= 1'b0;
    end else begin
      if (wr_fire) begin
        wr_first <= wr_last;
        if (wr_start) begin
          len[wr_bank] <= ncpc_ncbps(wr_ncpc);
          if (!rate_legal(rate_id)) rate_err <= 1'b1;
        end
        if (wr_last) begin
          full[wr_bank] <= 1'b1;
          wr_bank       <= !wr_bank;
        end
      end
      if (rd_issue) begin
        out_bits  <= mem[rd_bank][rd_idx];
        out_valid <= 1'b1;
        if (rd_last) begin
          full[rd_bank] <= 1'b0;
          rd_bank       <= !rd_bank;
          rd_idx        <= '0;
        end else begin
          rd_idx <= rd_idx + AW'(1);
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ofdm_interleaver.sv
// Directed bench for ofdm_interleaver: hand-computed single-bit permutations,
// random blocks against a formula model, streaming, backpressure and reset.
module tb_ofdm_interleaver;

  typedef logic [1279:0] blk_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] rate_id = 4'd0;
  logic       in_bits = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       out_bits;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       rate_err;

  int n_vec = 0;
  int n_bad = 0;
  int stalls = 0;
  bit rx_q[$];

  ofdm_interleaver dut (
    .clk       (clk),
    .reset     (reset),
    .rate_id   (rate_id),
    .in_bits   (in_bits),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_bits  (out_bits),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .rate_err  (rate_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) rx_q.push_back(out_bits);
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic int golden_j(input int k, input int ncpc);
    int ncbps, q, s, m;
    ncbps = 192 * ncpc;
    q = ncbps / 16;
    s = (ncpc == 6) ? 3 : (ncpc == 4) ? 2 : 1;
    m = q * (k % 16) + k / 16;
    return s * (m / s) + (m + ncbps - 16 * m / ncbps) % s;
  endfunction

  function automatic blk_t permute(input blk_t tx, input int ncpc);
    blk_t e = '0;
    for (int k = 0; k < 192 * ncpc; k++) e[golden_j(k, ncpc)] = tx[k];
    return e;
  endfunction

  function automatic blk_t rand_blk(input int n);
    blk_t v = '0;
    for (int k = 0; k < n; k++) v[k] = 1'($urandom_range(0, 1));
    return v;
  endfunction

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_bits  = 1'b0;
  endtask

  // rate_id is scrambled to an illegal value after bit 0 to show it is only
  // sampled at block start.
  task automatic send_block(input logic [3:0] rate, input int n, input blk_t tx);
    for (int k = 0; k < n; k++) begin
      int   t;
      logic rdy;
      rate_id  = (k == 0) ? rate : 4'hF;
      in_bits  = tx[k];
      in_valid = 1'b1;
      t   = 0;
      rdy = 1'b0;
      while (!rdy && t < 5000) begin
        @(negedge clk);
        rdy = in_ready;
        @(posedge clk);
        #1;
        if (!rdy) begin
          stalls++;
          t++;
        end
      end
      if (!rdy) begin
        check_eq("wr_timeout", 0, 1);
        return;
      end
    end
  endtask

  task automatic collect(input int n, output blk_t v);
    int t = 0;
    v = '0;
    while (rx_q.size() < n && t < 20000) begin
      @(negedge clk);
      t++;
    end
    if (rx_q.size() < n) check_eq("rx_timeout", rx_q.size(), n);
    for (int i = 0; i < n && rx_q.size() > 0; i++) v[i] = rx_q.pop_front();
  endtask

  task automatic check_block(input string tag, input blk_t got, input blk_t exp, input int n);
    for (int s = 0; s * 256 < n; s++)
      check_eq($sformatf("%s[%0d]", tag, s), got[s*256 +: 256], exp[s*256 +: 256]);
  endtask

  initial begin
    blk_t tx, got, exp;
    blk_t tq [3];
    int   gaps, t;
    logic snap;
    bit   moved;

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_bits", out_bits, 0);
    check_eq("rst_rate_err", rate_err, 0);
    reset = 1'b0;
    sync();

    // BPSK: k=1 -> index 12, exactly 192 outputs
    tx = '0; tx[1] = 1'b1;
    send_block(4'd0, 192, tx);
    idle();
    collect(192, got);
    exp = '0; exp[12] = 1'b1;
    check_block("bpsk_k1", got, exp, 192);
    check_eq("bpsk_ones", $countones(got), 1);
    repeat (20) @(negedge clk);
    check_eq("bpsk_extra", rx_q.size(), 0);
    check_eq("bpsk_idle_valid", out_valid, 0);

    // 16QAM: k=1 -> 49, k=0 -> 0
    sync();
    tx = '0; tx[1] = 1'b1;
    send_block(4'd3, 768, tx);
    tx = '0; tx[0] = 1'b1;
    send_block(4'd3, 768, tx);
    idle();
    collect(768, got);
    exp = '0; exp[49] = 1'b1;
    check_block("16qam_k1", got, exp, 768);
    collect(768, got);
    exp = '0; exp[0] = 1'b1;
    check_block("16qam_k0", got, exp, 768);

    // 64QAM: k=1 -> 74, then a random block against the formula model
    sync();
    tx = '0; tx[1] = 1'b1;
    send_block(4'd5, 1152, tx);
    tq[0] = rand_blk(1152);
    send_block(4'd5, 1152, tq[0]);
    idle();
    collect(1152, got);
    exp = '0; exp[74] = 1'b1;
    check_block("64qam_k1", got, exp, 1152);
    collect(1152, got);
    check_block("64qam_rand", got, permute(tq[0], 6), 1152);

    // Continuous QPSK: no bubble on out_valid, no stall on in_ready
    for (int i = 0; i < 3; i++) tq[i] = rand_blk(384);
    sync();
    stalls = 0;
    gaps = 0;
    fork
      begin
        send_block(4'd1, 384, tq[0]);
        send_block(4'd2, 384, tq[1]);
        send_block(4'd1, 384, tq[2]);
        idle();
      end
      begin
        t = 0;
        while (!out_valid && t < 2000) begin
          @(negedge clk);
          t++;
        end
        if (!out_valid) gaps = -1;
        else begin
          repeat (1151) begin
            @(negedge clk);
            if (!out_valid) gaps++;
          end
        end
      end
    join
    check_eq("qpsk_gaps", gaps, 0);
    check_eq("qpsk_stalls", stalls, 0);
    for (int i = 0; i < 3; i++) begin
      collect(384, got);
      check_block($sformatf("qpsk_blk%0d", i), got, permute(tq[i], 2), 384);
    end

    // Backpressure: both banks fill, output holds, then three blocks in order
    for (int i = 0; i < 3; i++) tq[i] = rand_blk(192);
    sync();
    out_ready = 1'b0;
    moved = 1'b0;
    fork
      begin
        send_block(4'd0, 192, tq[0]);
        send_block(4'd0, 192, tq[1]);
        send_block(4'd0, 192, tq[2]);
        idle();
      end
      begin
        repeat (500) @(negedge clk);
        snap = out_bits;
        repeat (500) begin
          @(negedge clk);
          if (out_bits !== snap) moved = 1'b1;
        end
        check_eq("bp_in_ready", in_ready, 0);
        check_eq("bp_out_valid", out_valid, 1);
        check_eq("bp_stable", moved, 0);
        check_eq("bp_head_bit", out_bits, tq[0][0]);
        check_eq("bp_none_taken", rx_q.size(), 0);
        sync();
        out_ready = 1'b1;
      end
    join
    for (int i = 0; i < 3; i++) begin
      collect(192, got);
      check_block($sformatf("bp_blk%0d", i), got, permute(tq[i], 1), 192);
    end
    check_eq("rate_err_legal", rate_err, 0);

    // Reset mid-write, then a clean 16QAM block
    sync();
    send_block(4'd5, 300, rand_blk(1152));
    reset = 1'b1;
    idle();
    #1;
    check_eq("rstw_in_ready", in_ready, 1);
    check_eq("rstw_out_valid", out_valid, 0);
    check_eq("rstw_out_bits", out_bits, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    sync();
    tq[0] = rand_blk(768);
    send_block(4'd4, 768, tq[0]);
    idle();
    collect(768, got);
    check_block("post_rstw", got, permute(tq[0], 4), 768);

    // Reset mid-read on an all-ones block
    sync();
    tx = '0;
    for (int k = 0; k < 192; k++) tx[k] = 1'b1;
    send_block(4'd0, 192, tx);
    idle();
    t = 0;
    while (rx_q.size() < 50 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    sync();
    check_eq("rstr_pre_valid", out_valid, 1);
    check_eq("rstr_pre_bits", out_bits, 1);
    reset = 1'b1;
    #1;
    check_eq("rstr_out_valid", out_valid, 0);
    check_eq("rstr_out_bits", out_bits, 0);
    check_eq("rstr_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    rx_q.delete();
    repeat (20) @(negedge clk);
    check_eq("rstr_flushed", rx_q.size(), 0);

    // Illegal rate_id 9: flagged and treated as BPSK
    sync();
    check_eq("pre9_rate_err", rate_err, 0);
    tx = '0; tx[1] = 1'b1;
    send_block(4'd9, 192, tx);
    idle();
    collect(192, got);
    exp = '0; exp[12] = 1'b1;
    check_block("rate9_perm", got, exp, 192);
    check_eq("rate9_err", rate_err, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
